// File: rtl/unified_buffer_stream_pkg.sv
// Shared types, default sizes and the bounds helper for the unified buffer
// and its address generators.
package ub_pkg;
    typedef enum logic {IDLE, STREAM} ub_state_t;

    localparam int DATA_W_DEF = 8;
    localparam int LANES_DEF  = 4;
    localparam int DEPTH_DEF  = 64;

    // True when [base, base+len) fits inside the buffer; evaluated at 32 bits so no wrap.
    function automatic logic in_bounds(input int unsigned base, input int unsigned len,
                                       input int unsigned depth = DEPTH_DEF);
        return (base + len) <= depth;
    endfunction
endpackage

// File: rtl/unified_buffer_stream_ctrl.sv
// Read-stream sequencer: bounds-checks a request, then walks the buffer one
// LANES-wide vector per accepted handshake.
module ub_stream_ctrl
    import ub_pkg::*;
#(
    parameter int LANES  = LANES_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rd_start,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [CNT_W-1:0]  rd_count,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic              rd_busy,
    output logic              load_en,
    output logic [ADDR_W-1:0] load_addr,
    output logic              rd_err
);
    ub_state_t         state_reg;
    logic              rd_valid_reg;
    logic [ADDR_W-1:0] ptr_reg;
    logic [CNT_W-1:0]  remaining_reg;

    always_comb begin
        load_en   = 1'b0;
        load_addr = ptr_reg;
        rd_err    = 1'b0;
        if (state_reg == IDLE) begin
            if (rd_start && rd_count != '0) begin
                if (in_bounds(32'(rd_addr), 32'(rd_count) * 32'(LANES), 32'(DEPTH))) begin
                    load_en   = 1'b1;
                    load_addr = rd_addr;
                end else begin
                    rd_err = 1'b1;
                end
            end
        end else if (rd_ready && remaining_reg != '0) begin
            load_en = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            rd_valid_reg  <= 1'b0;
            ptr_reg       <= '0;
            remaining_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (load_en) begin
                        state_reg     <= STREAM;
                        rd_valid_reg  <= 1'b1;
                        ptr_reg       <= rd_addr + ADDR_W'(LANES);
                        remaining_reg <= rd_count - CNT_W'(1);
                    end
                end
                STREAM: begin
                    if (rd_ready) begin
                        if (remaining_reg != '0) begin
                            ptr_reg       <= ptr_reg + ADDR_W'(LANES);
                            remaining_reg <= remaining_reg - CNT_W'(1);
                        end else begin
                            // Last vector accepted; rd_data keeps its final value.
                            rd_valid_reg <= 1'b0;
                            state_reg    <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign rd_valid = rd_valid_reg;
    assign rd_busy  = (state_reg != IDLE);
endmodule

// File: rtl/unified_buffer_stream.sv
// Unified activation/result buffer: burst writes from the accumulators, and
// handshaked multi-vector read streams toward the input-setup stage.
module unified_buffer_stream
    import ub_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LANES  = LANES_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    wr_en,
    input  logic                    wr_auto,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [LANES*DATA_W-1:0] wr_data,
    input  logic                    rd_start,
    input  logic [ADDR_W-1:0]       rd_addr,
    input  logic [CNT_W-1:0]        rd_count,
    input  logic                    rd_ready,
    output logic                    rd_valid,
    output logic [LANES*DATA_W-1:0] rd_data,
    output logic                    rd_busy,
    output logic [ADDR_W-1:0]       write_ptr,
    output logic                    err_oob,
    input  logic                    err_clear
);
    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [DATA_W-1:0] rd_lane_reg [LANES];
    logic [ADDR_W-1:0] write_ptr_reg;
    logic              err_reg;
    logic [ADDR_W-1:0] wr_base;
    logic              wr_ok;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic              rd_err;

    assign wr_base = wr_auto ? write_ptr_reg : wr_addr;
    assign wr_ok   = in_bounds(32'(wr_base), 32'(LANES), 32'(DEPTH));

    ub_stream_ctrl #(
        .LANES(LANES), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) u_ctrl (
        .clk(clk), .reset_n(reset_n),
        .rd_start(rd_start), .rd_addr(rd_addr), .rd_count(rd_count), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_busy(rd_busy),
        .load_en(load_en), .load_addr(load_addr), .rd_err(rd_err)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
        end else if (wr_en && wr_ok) begin
            for (int i = 0; i < LANES; i++)
                mem_reg[wr_base + ADDR_W'(i)] <= wr_data[i*DATA_W +: DATA_W];
        end
    end

    // Loads sample mem_reg before this edge's write lands: read-before-write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LANES; i++) rd_lane_reg[i] <= '0;
        end else if (load_en) begin
            for (int i = 0; i < LANES; i++)
                rd_lane_reg[i] <= mem_reg[load_addr + ADDR_W'(i)];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            write_ptr_reg <= '0;
            err_reg       <= 1'b0;
        end else begin
            if (wr_en && wr_ok) write_ptr_reg <= wr_base + ADDR_W'(LANES);
            // A fresh error outranks a clear in the same cycle.
            if ((wr_en && !wr_ok) || rd_err) err_reg <= 1'b1;
            else if (err_clear)              err_reg <= 1'b0;
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign rd_data[gi*DATA_W +: DATA_W] = rd_lane_reg[gi];
    end

    assign write_ptr = write_ptr_reg;
    assign err_oob   = err_reg;
endmodule
